conv_mac_engine: RTL

//  Parametrised successor of the single-layer conv datapath: row/col loop counter, address controller and LANES-wide MAC in one block.

---
 rtl/conv_mac_engine.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: row/column pixel sweep, buffer address generation and a
// LANES-wide signed multiply-accumulate. Each finished pixel is presented on a
// valid/ready result port.
// Optional build macro: CONV_RELU_EN -- when defined, negative partial sums are
// clamped to zero on o_out_data. Row/col/handshake timing is the same either way.
module conv_mac_engine #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int K_WORDS = 2,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ADDR_W  = 8,
  parameter int ACC_W   = 40,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int WORD_W = LANES * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ifm_en,
  output logic [ADDR_W-1:0] o_ifm_addr,
  input  logic [WORD_W-1:0] i_ifm_rdata,
  output logic              o_w_en,
  output logic [ADDR_W-1:0] o_w_addr,
  input  logic [WORD_W-1:0] i_w_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_data,
  output logic [ROW_W-1:0]  o_out_row,
  output logic [COL_W-1:0]  o_out_col
);

  localparam int KW = (K_WORDS > 1) ? $clog2(K_WORDS) : 1;
  localparam logic [KW-1:0]     K_LAST     = KW'(K_WORDS - 1);
  localparam logic [ROW_W-1:0]  R_LAST     = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  C_LAST     = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] PIX_STRIDE = ADDR_W'(K_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Full-precision signed dot product of one ifm word with one weight word.
  // Lane 0 sits in the MSBs of each word.
  function automatic logic signed [ACC_W-1:0] dot_f(
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b
  );
    logic signed [DATA_W-1:0]   ea;
    logic signed [DATA_W-1:0]   eb;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    sum;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      ea   = a[(LANES-1-i)*DATA_W +: DATA_W];
      eb   = b[(LANES-1-i)*DATA_W +: DATA_W];
      prod = (2*DATA_W)'(ea) * (2*DATA_W)'(eb);
      sum  = sum + ACC_W'(prod);
    end
    return sum;
  endfunction

  // Value presented to the consumer for a finished accumulator.
  function automatic logic [ACC_W-1:0] result_f(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W-1:0] res;
`ifdef CONV_RELU_EN
    if (acc[ACC_W-1]) begin
      res = '0;
    end else begin
      res = acc;
    end
`else
    res = acc;
`endif
    return res;
  endfunction

  state_t                   r_state;
  logic [KW-1:0]            r_k;
  logic [ROW_W-1:0]         r_r;
  logic [COL_W-1:0]         r_c;
  logic [ADDR_W-1:0]        r_base;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_en;
  logic                     r_dvld;
  logic [ADDR_W-1:0]        r_ifm_addr;
  logic [ADDR_W-1:0]        r_w_addr;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_out_valid;
  logic [ACC_W-1:0]         r_out_data;
  logic [ROW_W-1:0]         r_out_row;
  logic [COL_W-1:0]         r_out_col;

  state_t                   w_state_nxt;
  logic [KW-1:0]            w_k_nxt;
  logic [KW-1:0]            w_k_inc;
  logic [ROW_W-1:0]         w_r_nxt;
  logic [COL_W-1:0]         w_c_nxt;
  logic [ADDR_W-1:0]        w_base_nxt;
  logic [ADDR_W-1:0]        w_base_inc;
  logic signed [ACC_W-1:0]  w_dot;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic                     w_en_nxt;
  logic [ADDR_W-1:0]        w_ifm_addr_nxt;
  logic [ADDR_W-1:0]        w_w_addr_nxt;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;
  logic                     w_ovalid_nxt;
  logic [ACC_W-1:0]         w_odata_nxt;
  logic [ROW_W-1:0]         w_orow_nxt;
  logic [COL_W-1:0]         w_ocol_nxt;

  assign w_dot = dot_f(i_ifm_rdata, i_w_rdata);

  // Next-state, address, accumulator and output-port decisions for the layer sweep.
  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_r_nxt        = r_r;
    w_c_nxt        = r_c;
    w_base_nxt     = r_base;
    w_en_nxt       = 1'b0;
    w_ifm_addr_nxt = r_ifm_addr;
    w_w_addr_nxt   = r_w_addr;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_ovalid_nxt   = r_out_valid;
    w_odata_nxt    = r_out_data;
    w_orow_nxt     = r_out_row;
    w_ocol_nxt     = r_out_col;
    w_k_inc        = r_k + KW'(1);
    w_base_inc     = r_base + PIX_STRIDE;
    // Read data is only meaningful one cycle after an enabled read.
    if (r_dvld) begin
      w_acc_sum = r_acc + w_dot;
    end else begin
      w_acc_sum = r_acc;
    end
    w_acc_nxt = w_acc_sum;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_RUN;
          w_busy_nxt     = 1'b1;
          w_k_nxt        = '0;
          w_r_nxt        = '0;
          w_c_nxt        = '0;
          w_base_nxt     = '0;
          w_acc_nxt      = '0;
          w_en_nxt       = 1'b1;
          w_ifm_addr_nxt = '0;
          w_w_addr_nxt   = '0;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end

      S_RUN: begin
        if (r_k == K_LAST) begin
          // Last word already issued; its data lands during LAST.
          w_state_nxt = S_LAST;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt        = w_k_inc;
          w_en_nxt       = 1'b1;
          w_ifm_addr_nxt = r_base + ADDR_W'(w_k_inc);
          w_w_addr_nxt   = ADDR_W'(w_k_inc);
        end
      end

      S_LAST: begin
        // Final word is folded in here and captured straight into the output register.
        w_state_nxt  = S_OUT;
        w_ovalid_nxt = 1'b1;
        w_odata_nxt  = result_f(w_acc_sum);
        w_orow_nxt   = r_r;
        w_ocol_nxt   = r_c;
      end

      S_OUT: begin
        if (i_out_ready) begin
          w_ovalid_nxt = 1'b0;
          w_acc_nxt    = '0;
          w_k_nxt      = '0;
          if ((r_r == R_LAST) && (r_c == C_LAST)) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_r_nxt     = '0;
            w_c_nxt     = '0;
            w_base_nxt  = '0;
          end else begin
            w_state_nxt    = S_RUN;
            w_en_nxt       = 1'b1;
            w_base_nxt     = w_base_inc;
            w_ifm_addr_nxt = w_base_inc;
            w_w_addr_nxt   = '0;
            if (r_c == C_LAST) begin
              w_c_nxt = '0;
              w_r_nxt = r_r + ROW_W'(1);
            end else begin
              w_c_nxt = r_c + COL_W'(1);
            end
          end
        end else begin
          // Back-pressure: everything holds, no reads issued.
          w_en_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_busy_nxt   = 1'b0;
        w_ovalid_nxt = 1'b0;
      end
    endcase
  end

  // State, counters, datapath and registered outputs; reset aborts any layer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_base      <= '0;
      r_acc       <= '0;
      r_en        <= 1'b0;
      r_dvld      <= 1'b0;
      r_ifm_addr  <= '0;
      r_w_addr    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_r         <= w_r_nxt;
      r_c         <= w_c_nxt;
      r_base      <= w_base_nxt;
      r_acc       <= w_acc_nxt;
      r_en        <= w_en_nxt;
      r_dvld      <= r_en;
      r_ifm_addr  <= w_ifm_addr_nxt;
      r_w_addr    <= w_w_addr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_out_valid <= w_ovalid_nxt;
      r_out_data  <= w_odata_nxt;
      r_out_row   <= w_orow_nxt;
      r_out_col   <= w_ocol_nxt;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ifm_en    = r_en;
  assign o_w_en      = r_en;
  assign o_ifm_addr  = r_ifm_addr;
  assign o_w_addr    = r_w_addr;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_row   = r_out_row;
  assign o_out_col   = r_out_col;

endmodule
